// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encodings, the FSM state enum and the default XLEN.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // funct3[2] separates the divide/remainder group from the multiplies
  function automatic logic is_div_op(input op_e o);
    return o[2];
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to re-apply the result sign.
module muldiv_abs
  import muldiv_pkg::*;
#(
  parameter int W = XLEN_DEFAULT
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  // negate when requested, otherwise pass through
  always_comb begin
    val_o = neg_i ? (~val_i + W'(1)) : val_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one result bit per cycle.
// Optional feature macro: MULDIV_DIV_EN (defined = divider present; undefined =
// divide ops complete at once with result 0 and an illegal pulse).
//
// Handshake: start is sampled on a rising edge whenever the FSM is not in RUN
// (IDLE or DONE); acceptance latches op and operands, later input changes are
// ignored. busy is high exactly while in RUN, and a start seen during RUN is
// dropped (no queueing). done is a registered one-cycle pulse; result is
// updated only on the edge that raises done and is held until the next one.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output state_e          dbg_state_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] sr_q, sr_d;         // shared product / {remainder, quotient}
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ill_q, ill_d;       // illegal flag pending for the done pulse
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;

  // ---------------- input decode ----------------
  op_e             op_in;
  logic            in_div, in_rem, sgn1, sgn2, neg_in;
  logic [XLEN-1:0] mag1, mag2;

  assign op_in  = op_e'(op);
  assign in_div = is_div_op(op_in);
  assign in_rem = (op_in == OP_REM) || (op_in == OP_REMU);
  assign sgn1   = rs1_val[XLEN-1] &
                  ~((op_in == OP_MULHU) || (op_in == OP_DIVU) || (op_in == OP_REMU));
  assign sgn2   = rs2_val[XLEN-1] &
                  ((op_in == OP_MUL) || (op_in == OP_MULH) ||
                   (op_in == OP_DIV) || (op_in == OP_REM));
  // remainder follows the dividend; products and quotients follow the XOR
  assign neg_in = in_rem ? sgn1 : (sgn1 ^ sgn2);

  muldiv_abs #(.W(XLEN)) u_abs_rs1 (.val_i(rs1_val), .neg_i(sgn1), .val_o(mag1));
  muldiv_abs #(.W(XLEN)) u_abs_rs2 (.val_i(rs2_val), .neg_i(sgn2), .val_o(mag2));

  // ---------------- special cases resolved at acceptance ----------------
  logic            spec_hit, spec_ill;
  logic [XLEN-1:0] spec_val;

`ifdef MULDIV_DIV_EN
  logic div0, ovf;
  assign div0 = in_div && (rs2_val == '0);
  assign ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                (rs1_val == SMIN) && (rs2_val == '1);

  // divide-by-zero and signed overflow have architecturally fixed results
  always_comb begin
    spec_hit = div0 | ovf;
    spec_ill = 1'b0;
    if (div0) spec_val = in_rem ? rs1_val : '1;
    else      spec_val = in_rem ? '0 : SMIN;
  end
`else
  // without the divider every divide op completes at once as illegal
  always_comb begin
    spec_hit = in_div;
    spec_ill = 1'b1;
    spec_val = '0;
  end
`endif

  // ---------------- one iteration of the shared datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, step;

  assign mul_sum  = {1'b0, sr_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign mul_next = sr_q[0] ? {mul_sum, sr_q[XLEN-1:1]} : {1'b0, sr_q[2*XLEN-1:1]};

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     rem_sh;           // remainder shifted left with guard bit
  logic [XLEN+1:0]   trial;
  logic              q_bit;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_next;
  logic              unused_trial;

  assign rem_sh       = sr_q[2*XLEN-1:XLEN-1];
  assign trial        = {1'b0, rem_sh} - {2'b00, opnd_q};
  assign q_bit        = ~trial[XLEN+1];
  // the remainder always fits XLEN bits because it stays below the divisor
  assign rem_new      = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_next     = {rem_new, sr_q[XLEN-2:0], q_bit};
  assign unused_trial = trial[XLEN];
  assign step         = is_div_op(op_q) ? div_next : mul_next;
`else
  assign step = mul_next;
`endif

  // ---------------- result selection and sign correction ----------------
  logic [XLEN-1:0] lo, hi, sel_raw, sel_fix, res_final;
  logic            is_mulh;

  assign lo      = sr_q[XLEN-1:0];
  assign hi      = sr_q[2*XLEN-1:XLEN];
  assign is_mulh = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_MULHU);

  // low word for MUL and quotients, high word for MULH* and remainders
  always_comb begin
    case (op_q)
      OP_MUL, OP_DIV, OP_DIVU: sel_raw = lo;
      default:                 sel_raw = hi;
    endcase
  end

  muldiv_abs #(.W(XLEN)) u_abs_res (.val_i(sel_raw), .neg_i(neg_q), .val_o(sel_fix));

  // a 2*XLEN negate only carries into the high word when the low word is zero
  assign res_final = (is_mulh && neg_q && (lo != '0)) ? ~hi : sel_fix;

  // ---------------- FSM: next state and datapath control ----------------
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    opnd_d    = opnd_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ill_d     = ill_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          result_d  = res_final;
          done_d    = 1'b1;
          illegal_d = ill_q;
          state_d   = IDLE;
        end
        if (start) begin
          op_d   = op_in;
          cnt_d  = '0;
          ill_d  = spec_hit & spec_ill;
          opnd_d = in_div ? mag2 : mag1;
          if (spec_hit) begin
            // both halves carry the fixed value so either word selection works
            sr_d    = {spec_val, spec_val};
            neg_d   = 1'b0;
            state_d = DONE;
          end else begin
            sr_d    = in_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            neg_d   = neg_in;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        sr_d  = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      opnd_q    <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      ill_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      opnd_q    <= opnd_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ill_q     <= ill_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign result      = result_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule
